parallel_pattern_tx: RTL

- FIFO reader / 8-lane transmitter; the output-side counterpart of the 8-lane parallel capture path.
- On start it emits a fixed header pattern, then unpacks NWORDS 36-bit FIFO words into 8-bit samples. One sample is driven on lanes fd0..fd7 per clock.
- Drives the chip's parallel digital inputs for loopback and pattern tests; the FIFO is filled by the host.

---
 rtl/pixel_cfg_pkg.sv | 37 +++
 rtl/parallel_pattern_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_cfg_pkg.sv
// ---------------------------------------------------------------------------
// pixel_cfg_pkg
// Definitions shared by the 8-lane parallel capture path and its transmit
// counterpart (parallel_pattern_tx):
//   - tx_state_e        : transmitter FSM state encoding
//   - SAMPLES_PER_WORD  : 8-bit samples packed into one FIFO word
//   - LANE_WIDTH        : number of parallel lanes (bits per sample)
//   - DEFAULT_HEADER    : lane pattern that marks the start of a burst
//   - DEFAULT_IDLE_PATTERN : lane pattern driven between bursts
//   - lane_select()     : extracts one sample from a packed word
// ---------------------------------------------------------------------------
package pixel_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_HEADER = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } tx_state_e;

  localparam int SAMPLES_PER_WORD = 4;
  localparam int LANE_WIDTH       = 8;
  localparam int WORD_BITS        = SAMPLES_PER_WORD * LANE_WIDTH;

  localparam logic [LANE_WIDTH-1:0] DEFAULT_HEADER       = 8'hA5;
  localparam logic [LANE_WIDTH-1:0] DEFAULT_IDLE_PATTERN = 8'h00;

  // Sample idx of a packed word; sample 0 sits in the low byte.
  function automatic logic [LANE_WIDTH-1:0] lane_select(
    input logic [WORD_BITS-1:0] word,
    input logic [1:0]           idx
  );
    return word[LANE_WIDTH*idx +: LANE_WIDTH];
  endfunction

endpackage

// File: rtl/parallel_pattern_tx.sv
// ---------------------------------------------------------------------------
// parallel_pattern_tx
// FIFO reader feeding 8 parallel output lanes. On start it waits for the
// FIFO to hold data, drives HEADER for HEADER_LEN cycles, then unpacks
// NWORDS FIFO words (4 samples each, low byte first) onto fd0..fd7, one
// sample per clock with no gap between words.
//
// Ports:
//   clk, rst_n    clock (rising edge) / asynchronous active-low reset
//   start         begins a burst; only looked at while idle
//   fifo_empty    FIFO status
//   fifo_dout     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    FIFO read strobe (never raised while fifo_empty=1)
//   fd0..fd7      registered lanes, fd0 = sample bit 0
//   busy          high while a burst is in progress
//   done          one-cycle pulse after the last sample of a full burst
//   underrun      sticky: FIFO ran dry mid-burst; cleared by next start
// ---------------------------------------------------------------------------
module parallel_pattern_tx
  import pixel_cfg_pkg::*;
#(
  parameter int                     NWORDS       = 100,
  parameter int                     FIFO_WIDTH   = 36,
  parameter logic [LANE_WIDTH-1:0]  HEADER       = DEFAULT_HEADER,
  parameter int                     HEADER_LEN   = 4,
  parameter logic [LANE_WIDTH-1:0]  IDLE_PATTERN = DEFAULT_IDLE_PATTERN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  fd0,
  output logic                  fd1,
  output logic                  fd2,
  output logic                  fd3,
  output logic                  fd4,
  output logic                  fd5,
  output logic                  fd6,
  output logic                  fd7,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam int HCNT_W = $clog2(HEADER_LEN);
  localparam int IDX_W  = 2;

  localparam logic [CNT_W-1:0]  LAST_WORD    = CNT_W'(NWORDS - 1);
  localparam logic [HCNT_W-1:0] HDR_LAST     = HCNT_W'(HEADER_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_PREFETCH = IDX_W'(SAMPLES_PER_WORD - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(SAMPLES_PER_WORD - 1);

  tx_state_e              state_q, state_d;
  logic [HCNT_W-1:0]      hcnt_q,  hcnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [CNT_W-1:0]       wcnt_q,  wcnt_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [LANE_WIDTH-1:0]  fd_q,    fd_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;
  logic                   under_q, under_d;
  logic                   is_last_word;

  // Only the 4 packed samples are transmitted; the tag bits above them
  // are intentionally dropped.
  if (FIFO_WIDTH > WORD_BITS) begin : g_tag_bits
    logic unused_tag;
    assign unused_tag = ^fifo_dout[FIFO_WIDTH-1:WORD_BITS];
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    shift_d      = shift_q;
    under_d      = under_q;
    fifo_rd_en   = 1'b0;
    is_last_word = (wcnt_q == LAST_WORD);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          under_d = 1'b0;
          wcnt_d  = '0;
        end
      end

      ST_ARM: begin
        if (!fifo_empty) begin
          state_d = ST_HEADER;
          hcnt_d  = '0;
        end
      end

      ST_HEADER: begin
        // ARM only exits on a non-empty FIFO, so the first read is safe.
        if (hcnt_q == '0) fifo_rd_en = 1'b1;
        if (hcnt_q == HCNT_W'(1)) shift_d = fifo_dout[WORD_BITS-1:0];
        if (hcnt_q == HDR_LAST) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end

      ST_DATA: begin
        // Fetch the next word two samples early so it lands exactly when
        // the current word's last sample is on the lanes.
        if (idx_q == IDX_PREFETCH && !is_last_word) begin
          if (!fifo_empty) fifo_rd_en = 1'b1;
          else             under_d    = 1'b1;
        end
        if (idx_q == IDX_LAST) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (is_last_word) begin
            state_d = ST_DONE;
          end else if (under_q) begin
            // Prefetch failed: finish this word, then abandon the burst.
            state_d = ST_IDLE;
          end else begin
            shift_d = fifo_dout[WORD_BITS-1:0];
            idx_d   = '0;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up
    // with the state register in the same cycle.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    unique case (state_d)
      ST_HEADER: fd_d = HEADER;
      ST_DATA:   fd_d = lane_select(shift_d, idx_d);
      default:   fd_d = IDLE_PATTERN;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      shift_q <= '0;
      fd_q    <= IDLE_PATTERN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      shift_q <= shift_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  assign fd0      = fd_q[0];
  assign fd1      = fd_q[1];
  assign fd2      = fd_q[2];
  assign fd3      = fd_q[3];
  assign fd4      = fd_q[4];
  assign fd5      = fd_q[5];
  assign fd6      = fd_q[6];
  assign fd7      = fd_q[7];
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = under_q;

endmodule
